// File: rtl/reg_display_shadow.sv
// reg_display_shadow: shadows r0..r7 from the register-file write port and feeds a freezable view to the display.
// Optional write counter while frozen is enabled by defining REG_DISPLAY_WR_COUNT_EN.
module reg_display_shadow #(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              freeze_btn,
  output logic [DATA_W-1:0] reg_0,
  output logic [DATA_W-1:0] reg_1,
  output logic [DATA_W-1:0] reg_2,
  output logic [DATA_W-1:0] reg_3,
  output logic [DATA_W-1:0] reg_4,
  output logic [DATA_W-1:0] reg_5,
  output logic [DATA_W-1:0] reg_6,
  output logic [DATA_W-1:0] reg_7,
  output logic              frozen,
  output logic [7:0]        dirty,
  output logic              update_pulse,
  output logic [15:0]       wr_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {LIVE, FROZEN, CATCHUP} state_t;
  state_t state, nxt;
  logic sync_a, sync_b, level, strobe;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] shadow [8];
  logic [DATA_W-1:0] disp [8];
  // press strobe fires on the cycle the accepted level is about to fall
  assign strobe = level && !sync_b && cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
    end else begin
      sync_a <= freeze_btn;
      sync_b <= sync_a;
      if (sync_b == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_b;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  always_comb begin
    nxt = state;
    if (state == CATCHUP) nxt = LIVE;
    else if (strobe) nxt = (state == LIVE) ? FROZEN : CATCHUP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LIVE;
      frozen <= 1'b0;
    end else begin
      state  <= nxt;
      frozen <= nxt == FROZEN;
    end
  end
  // a write during catch-up lands after the shadow copy, so it wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        disp[i]   <= '0;
      end
      dirty        <= '0;
      update_pulse <= 1'b0;
    end else begin
      update_pulse <= (state == LIVE && wr_en) || state == CATCHUP;
      if (state == CATCHUP) begin
        for (int i = 0; i < 8; i++) disp[i] <= shadow[i];
        dirty <= '0;
      end
      if (wr_en) begin
        shadow[wr_addr] <= wr_data;
        if (state == FROZEN) dirty[wr_addr] <= 1'b1;
        else disp[wr_addr] <= wr_data;
      end
    end
  end
`ifdef REG_DISPLAY_WR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_count <= '0;
    else if (state == CATCHUP) wr_count <= '0;
    else if (state == FROZEN && wr_en && wr_count != 16'hFFFF) wr_count <= wr_count + 1'b1;
  end
`else
  assign wr_count = '0;
`endif
  assign reg_0 = disp[0];
  assign reg_1 = disp[1];
  assign reg_2 = disp[2];
  assign reg_3 = disp[3];
  assign reg_4 = disp[4];
  assign reg_5 = disp[5];
  assign reg_6 = disp[6];
  assign reg_7 = disp[7];
endmodule

// File: tb/tb_reg_display_shadow.sv
// tb_reg_display_shadow: randomized bench for reg_display_shadow against a window-based behavioural model.
module tb_reg_display_shadow;
  localparam int D = 8;
  logic clk = 0;
  logic rst_n = 1;
  logic wr_en = 0;
  logic [2:0] wr_addr = 0;
  logic [15:0] wr_data = 0;
  logic freeze_btn = 1;
  logic [15:0] rv [8];
  logic frozen, update_pulse;
  logic [7:0] dirty;
  logic [15:0] wr_count;
  int errors = 0;
  int checks = 0;
  reg_display_shadow #(.DATA_W(16), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .freeze_btn(freeze_btn),
    .reg_0(rv[0]), .reg_1(rv[1]), .reg_2(rv[2]), .reg_3(rv[3]),
    .reg_4(rv[4]), .reg_5(rv[5]), .reg_6(rv[6]), .reg_7(rv[7]),
    .frozen(frozen), .dirty(dirty), .update_pulse(update_pulse), .wr_count(wr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
`ifdef REG_DISPLAY_WR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  // model: 0 live, 1 frozen, 2 catch-up; hist[j] = raw button sampled j+1 edges ago
  int m_mode = 0;
  logic m_acc = 1;
  logic [31:0] hist = '1;
  logic [15:0] m_shadow [8] = '{default: 16'h0};
  logic [15:0] m_disp [8] = '{default: 16'h0};
  logic [7:0] m_dirty = 0;
  logic m_upd = 0;
  logic [15:0] m_wrc = 0;
  initial begin
    logic [D-1:0] win;
    logic strobe;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_mode = 0; m_acc = 1; hist = '1; m_dirty = 0; m_upd = 0; m_wrc = 0;
        for (int i = 0; i < 8; i++) begin
          m_shadow[i] = 0;
          m_disp[i] = 0;
        end
      end
      for (int i = 0; i < 8; i++) chk($sformatf("reg_%0d", i), 32'(rv[i]), 32'(m_disp[i]));
      chk("frozen", 32'(frozen), 32'(m_mode == 1));
      chk("dirty", 32'(dirty), 32'(m_dirty));
      chk("update_pulse", 32'(update_pulse), 32'(m_upd));
      chk("wr_count", 32'(wr_count), CNT_EN ? 32'(m_wrc) : 32'h0);
      if (rst_n) begin
        win = hist[D:1];
        strobe = m_acc && win == '0;
        if (m_acc ? win == '0 : win == '1) m_acc = !m_acc;
        hist = {hist[30:0], freeze_btn};
        m_upd = 0;
        case (m_mode)
          0: begin
            if (wr_en) m_disp[wr_addr] = wr_data;
            m_upd = wr_en;
            if (strobe) m_mode = 1;
          end
          1: begin
            if (wr_en) begin
              m_dirty[wr_addr] = 1'b1;
              if (m_wrc != 16'hFFFF) m_wrc++;
            end
            if (strobe) m_mode = 2;
          end
          default: begin
            m_disp = m_shadow;
            if (wr_en) m_disp[wr_addr] = wr_data;
            m_dirty = 0; m_wrc = 0; m_upd = 1; m_mode = 0;
          end
        endcase
        if (wr_en) m_shadow[wr_addr] = wr_data;
      end
    end
  end
  task automatic cyc(input logic we, input logic [2:0] a, input logic [15:0] d);
    wr_en = we; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0);
  endtask
  initial begin
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg_3", 32'(rv[3]), 0);
    chk("rst_frozen", 32'(frozen), 0);
    rst_n = 1;
    idle(2);
    cyc(1, 3, 16'h00A5);
    chk("live_reg_3", 32'(rv[3]), 32'h00A5);
    chk("live_pulse", 32'(update_pulse), 1);
    chk("live_reg_0", 32'(rv[0]), 0);
    chk("live_frozen", 32'(frozen), 0);
    idle(1);
    chk("live_pulse_end", 32'(update_pulse), 0);
    freeze_btn = 0;
    idle(D - 1);
    freeze_btn = 1;
    idle(14);
    chk("glitch_frozen", 32'(frozen), 0);
    freeze_btn = 0;
    idle(9);
    chk("press_early", 32'(frozen), 0);
    idle(1);
    chk("press_frozen", 32'(frozen), 1);
    freeze_btn = 1;
    idle(12);
    cyc(1, 1, 16'h1234);
    cyc(1, 1, 16'hBEEF);
    cyc(1, 7, 16'h0001);
    chk("frz_reg_1", 32'(rv[1]), 0);
    chk("frz_reg_7", 32'(rv[7]), 0);
    chk("frz_dirty", 32'(dirty), 32'h82);
    chk("frz_wr_count", 32'(wr_count), CNT_EN ? 32'd3 : 32'd0);
    cyc(1, 2, 16'h1111);
    idle(1);
    freeze_btn = 0;
    idle(10);
    chk("catchup_frozen", 32'(frozen), 0);
    cyc(1, 2, 16'h5555);
    chk("cu_reg_1", 32'(rv[1]), 32'hBEEF);
    chk("cu_reg_7", 32'(rv[7]), 32'h0001);
    chk("cu_reg_2", 32'(rv[2]), 32'h5555);
    chk("cu_dirty", 32'(dirty), 0);
    chk("cu_wr_count", 32'(wr_count), 0);
    chk("cu_pulse", 32'(update_pulse), 1);
    idle(1);
    chk("cu_pulse_end", 32'(update_pulse), 0);
    freeze_btn = 1;
    idle(12);
    freeze_btn = 0;
    idle(10);
    freeze_btn = 1;
    cyc(1, 4, 16'h4444);
    idle(1);
    chk("frz2_dirty", 32'(dirty), 32'h10);
    #3 rst_n = 0;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("arst_reg_%0d", i), 32'(rv[i]), 0);
    chk("arst_dirty", 32'(dirty), 0);
    chk("arst_frozen", 32'(frozen), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    idle(2);
    cyc(1, 5, 16'hCAFE);
    chk("post_rst_reg_5", 32'(rv[5]), 32'hCAFE);
    chk("post_rst_pulse", 32'(update_pulse), 1);
    for (int n = 0; n < 300; n++) begin
      freeze_btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 20)) cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_display_shadow.md
Name: reg_display_shadow

Overview:
- Upstream feeder for the 8-register seven-segment display stage.
- Snoops the CPU register-file write port (wr_en/wr_addr/wr_data) and keeps a shadow copy of r0..r7.
- Presents a registered, optionally frozen view of r0..r7 on reg_0..reg_7 for the display stage.
- A debounced pushbutton toggles between a live view and a frozen snapshot. Frozen mode keeps tracking writes internally and catches up on release.

Parameters:
- DATA_W, 16, register width.
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a button level change (≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  register-file write strobe, sampled on rising clk.
- wr_addr  in  3  destination register index.
- wr_data  in  DATA_W  write data.
- freeze_btn  in  1  raw pushbutton, active-low, asynchronous to clk.
- reg_0..reg_7  out  DATA_W each  displayed register values, registered.
- frozen  out  1  1 while the FROZEN state is active.
- dirty  out  8  bit i set when r_i was written while frozen.
- update_pulse  out  1  one-cycle pulse whenever any reg_x output changes source data (live write or catch-up).
- wr_count  out  16  writes counted while frozen (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - shadow[0..7] = 0, reg_0..reg_7 = 0, dirty = 0, frozen = 0, update_pulse = 0, wr_count = 0.
  - State = LIVE; synchronizer and debounce counter cleared to the button-released level (1).
- Button input path:
  - freeze_btn passes through a 2-flop synchronizer.
  - Debounce counter resets whenever the synchronized level differs from the accepted level.
  - The accepted level updates after DEBOUNCE_CYCLES consecutive cycles of the new level.
  - A press event is a 1→0 transition of the accepted level, producing a 1-cycle internal strobe. Releases generate nothing.
  - Minimum press-to-strobe latency is 2 + DEBOUNCE_CYCLES cycles.
- Shadow: on every cycle with wr_en=1, shadow[wr_addr] <= wr_data, in all states.
- State LIVE:
  - A write also loads reg_[wr_addr] <= wr_data in the same edge, so the output is valid 1 cycle after the write.
  - update_pulse=1 the cycle after that write.
  - A press strobe moves to FROZEN. A write on the strobe cycle still reaches reg_x; freezing starts the following cycle.
- State FROZEN:
  - reg_0..reg_7 hold their values; frozen=1.
  - A write sets dirty[wr_addr]=1 and updates the shadow only.
  - A press strobe moves to CATCHUP.
- State CATCHUP (exactly 1 cycle):
  - All reg_i <= shadow[i], dirty <= 0, update_pulse=1 the next cycle, then go to LIVE.
  - frozen drops to 0 on entry to CATCHUP.
  - A write during CATCHUP bypasses the shadow: reg_[wr_addr] <= wr_data, so no stale value is lost.
- Repeated writes to the same index: the last write wins, in the shadow and in reg_x.
- A press strobe while in CATCHUP is ignored. Debounce makes this unreachable in practice, but the rule is defined.
- Reset asserted mid-operation (any state) returns to LIVE with all outputs zero. Pending dirty bits are discarded.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: REG_DISPLAY_WR_COUNT_EN.
- When defined:
  - wr_count increments by 1 for each wr_en=1 cycle while in FROZEN, saturating at 16'hFFFF.
  - wr_count clears to 0 on the CATCHUP cycle.
- When undefined: wr_count is tied to 16'h0000 and no counter logic is synthesized. The port remains present so the top-level wiring does not change.

Test Plan:
- Reset, then write r3=16'h00A5 in LIVE: reg_3=16'h00A5 one cycle after the write edge, update_pulse high for 1 cycle, other regs 0, frozen=0.
- Glitchy press: freeze_btn pulses low for DEBOUNCE_CYCLES-1 cycles (DEBOUNCE_CYCLES=8 in the bench) → no state change, frozen stays 0. Then hold low for 10 cycles → frozen=1 after 2+8 cycles.
- While FROZEN, write r1=16'h1234 then r1=16'hBEEF, and r7=16'h0001:
  - reg_1 and reg_7 unchanged; dirty=8'b1000_0010.
  - With REG_DISPLAY_WR_COUNT_EN: wr_count=3.
- Release, then press again: CATCHUP cycle → reg_1=16'hBEEF, reg_7=16'h0001, dirty=0, wr_count=0, update_pulse one cycle, state LIVE.
- Write r2=16'h5555 exactly on the CATCHUP cycle while shadow r2=16'h1111 → reg_2=16'h5555 afterwards.
- Assert rst_n low while FROZEN with dirty≠0 (asynchronous, mid-cycle) → all reg_x=0, dirty=0, frozen=0 immediately. After release, a new write in LIVE propagates normally.
